game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter GROUND_Y, default 10'd400: player Y position when grounded.
REQ-002 SHALL have parameter JUMP_Y, default 10'd300: player Y position while airborne.
REQ-003 SHALL have parameter AIR_TICKS, default 120: number of frame ticks spent airborne per jump, range 1..1023.
REQ-004 SHALL have port clk3, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port jump, input, 1 bit: jump/start button, synchronous to clk3, level-sensitive.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle frame strobe.
REQ-008 SHALL have port hit, input, 1 bit: collision flag from the renderer, level-sensitive.
REQ-009 SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 AIR, 3 OVER.
REQ-010 SHALL have port player_y, output, 10 bits: current player Y position.
REQ-011 SHALL have port floating, output, 1 bit: high exactly when state is AIR.
REQ-012 SHALL have port game_over, output, 1 bit: high exactly when state is OVER.
REQ-013 SHALL have port score, output, 14 bits: frames survived.

Function
REQ-014 SHALL register jump once (jump_q) and act only on a rising edge (jump & ~jump_q); a held button SHALL produce one event.
REQ-015 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-016 In IDLE: a jump edge SHALL move to RUN and clear score to 0; hit and tick are ignored.
REQ-017 In RUN: hit=1 SHALL move to OVER; otherwise a jump edge SHALL move to AIR, clear the air counter and set player_y=JUMP_Y on the same edge.
REQ-018 In AIR: a tick SHALL increment the 10-bit air counter.
REQ-019 In AIR: a tick when the counter equals AIR_TICKS-1 SHALL move to RUN and set player_y=GROUND_Y.
REQ-020 In AIR: jump edges SHALL be ignored (no double jump); hit=1 SHALL move to OVER.
REQ-021 hit SHALL have priority over a jump edge and over air-counter expiry in the same cycle.
REQ-022 In OVER: player_y, score and air counter SHALL hold; a jump edge SHALL move to IDLE and set player_y=GROUND_Y.
REQ-023 Airborne duration SHALL be exactly AIR_TICKS ticks, measured from the jump edge to the return to RUN.
REQ-024 A tick arriving in the same cycle as the jump edge SHALL NOT be counted.
REQ-025 The score behaviour SHALL be as defined under Configuration.
REQ-026 States 0..3 SHALL be fully decoded, with no illegal encodings.

Reset
REQ-027 Asserting rst SHALL immediately (asynchronously) force: state=IDLE, player_y=GROUND_Y, score=0, air counter=0, jump_q=0, floating=0, game_over=0.
REQ-028 rst asserted mid-jump or in OVER SHALL abandon the operation with no residual state.
REQ-029 The first jump edge after deassertion SHALL be detected only if jump was low in at least one cycle after deassertion.

Configuration
REQ-030 SHALL use macro GAME_SCORE_EN to compile the score counter in or out.
REQ-031 With GAME_SCORE_EN defined, score SHALL increment on each tick in RUN or AIR.
REQ-032 With GAME_SCORE_EN defined, score SHALL saturate at 14'd9999.
REQ-033 With GAME_SCORE_EN defined, a tick in the cycle of the transition to OVER SHALL NOT count.
REQ-034 With GAME_SCORE_EN undefined, score SHALL be constant 0 and no counter logic SHALL be synthesised.
REQ-035 With GAME_SCORE_EN undefined, all other behaviour SHALL be identical to the defined case.

Verification (AIR_TICKS=4, GAME_SCORE_EN defined)
REQ-036 SHALL cover: reset, then jump pulse -> state=1, score=0, player_y=400.
REQ-037 SHALL cover: in RUN, jump edge then 4 ticks -> state=2 and player_y=300 for the first 3 ticks; state=1 and player_y=400 after the 4th tick; score=4.
REQ-038 SHALL cover: jump held high for 20 cycles in RUN -> one AIR entry only; a second edge during AIR -> no effect.
REQ-039 SHALL cover: hit=1 and jump edge in the same RUN cycle -> state=3, game_over=1, player_y=400; a later jump edge -> state=0.
REQ-040 SHALL cover: score preloaded via 10000 ticks -> score=9999 and holds.
REQ-041 SHALL cover: rst pulse mid-AIR, asynchronous to the clock -> state=0, player_y=400 before the next clk3 edge.

Source files
------------

// File: rtl/game_controller.sv
// Runner-game controller: jump/air/collision FSM driving player height, status flags and score.
// Optional score counter compiled in with `define GAME_SCORE_EN; otherwise score is constant 0.
module game_controller #(
  parameter logic [9:0]  GROUND_Y  = 10'd400,
  parameter logic [9:0]  JUMP_Y    = 10'd300,
  parameter int unsigned AIR_TICKS = 120
) (
  input  logic        clk3,
  input  logic        rst,
  input  logic        jump,
  input  logic        tick,
  input  logic        hit,
  output logic [1:0]  state,
  output logic [9:0]  player_y,
  output logic        floating,
  output logic        game_over,
  output logic [13:0] score
);

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned SCORE_W   = 14;
  localparam logic [CNT_W-1:0]   AIR_LAST  = CNT_W'(AIR_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             jump_q;
  logic             armed;
  logic             jump_edge;
  logic [CNT_W-1:0] air_cnt, air_cnt_d;
  logic [9:0]       player_y_d;

  // armed blocks a button held through reset from counting as a press
  assign jump_edge = jump & ~jump_q & armed;
  assign state     = state_q;

  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      jump_q    <= 1'b0;
      armed     <= 1'b0;
      air_cnt   <= '0;
      player_y  <= GROUND_Y;
      floating  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      jump_q    <= jump;
      armed     <= armed | ~jump;
      air_cnt   <= air_cnt_d;
      player_y  <= player_y_d;
      floating  <= (state_d == AIR);
      game_over <= (state_d == OVER);
    end
  end

  // next-state: hit outranks both a jump press and air-time expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (jump_edge) state_d = RUN;
      RUN: begin
        if (hit)            state_d = OVER;
        else if (jump_edge) state_d = AIR;
      end
      AIR: begin
        if (hit)                               state_d = OVER;
        else if (tick && (air_cnt == AIR_LAST)) state_d = RUN;
      end
      OVER: if (jump_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values; a tick on the launch cycle is not air time
  always_comb begin
    air_cnt_d  = air_cnt;
    player_y_d = player_y;
    unique case (state_q)
      RUN: begin
        if (!hit && jump_edge) begin
          air_cnt_d  = '0;
          player_y_d = JUMP_Y;
        end
      end
      AIR: begin
        if (!hit && tick) begin
          air_cnt_d = air_cnt + CNT_W'(1);
          if (air_cnt == AIR_LAST) player_y_d = GROUND_Y;
        end
      end
      OVER: if (jump_edge) player_y_d = GROUND_Y;
      default: ;
    endcase
  end

`ifdef GAME_SCORE_EN
  logic [SCORE_W-1:0] score_d;

  // frames survived; the tick of a collision cycle does not count
  always_comb begin
    score_d = score;
    if (state_q == IDLE && jump_edge)
      score_d = '0;
    else if ((state_q == RUN || state_q == AIR) && tick && !hit && score != SCORE_MAX)
      score_d = score + SCORE_W'(1);
  end

  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) score <= '0;
    else     score <= score_d;
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller (AIR_TICKS=4); follows GAME_SCORE_EN if defined.
module tb_game_controller;

  localparam int AT   = 4;
  localparam int GY   = 400;
  localparam int JY   = 300;
  localparam int SMAX = 9999;

  logic        clk3 = 1'b0;
  logic        rst, jump, tick, hit;
  logic [1:0]  state;
  logic [9:0]  player_y;
  logic        floating, game_over;
  logic [13:0] score;

  typedef struct {
    int st;
    int y;
    int fl;
    int go;
    int sc;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  int m_state, m_y, m_cnt, m_score, m_jq, m_armed;

  game_controller #(.GROUND_Y(10'd400), .JUMP_Y(10'd300), .AIR_TICKS(AT)) dut (
    .clk3(clk3), .rst(rst), .jump(jump), .tick(tick), .hit(hit),
    .state(state), .player_y(player_y), .floating(floating),
    .game_over(game_over), .score(score)
  );

  always #5 clk3 = ~clk3;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.st = m_state;
    e.y  = m_y;
    e.fl = (m_state == 2) ? 1 : 0;
    e.go = (m_state == 3) ? 1 : 0;
`ifdef GAME_SCORE_EN
    e.sc = m_score;
`else
    e.sc = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_state"}, int'(state), e.st);
    check({tag, "_player_y"}, int'(player_y), e.y);
    check({tag, "_floating"}, int'(floating), e.fl);
    check({tag, "_game_over"}, int'(game_over), e.go);
    check({tag, "_score"}, int'(score), e.sc);
  endtask

  task automatic model_reset();
    m_state = 0; m_y = GY; m_cnt = 0; m_score = 0; m_jq = 0; m_armed = 0;
  endtask

  task automatic model_step(input int j, input int t, input int h);
    int edge_ev;
    edge_ev = (j == 1 && m_jq == 0 && m_armed == 1) ? 1 : 0;
    case (m_state)
      0: if (edge_ev == 1) begin m_state = 1; m_score = 0; end
      1: begin
        if (h == 1) m_state = 3;
        else begin
          if (t == 1 && m_score < SMAX) m_score++;
          if (edge_ev == 1) begin m_state = 2; m_cnt = 0; m_y = JY; end
        end
      end
      2: begin
        if (h == 1) m_state = 3;
        else if (t == 1) begin
          if (m_score < SMAX) m_score++;
          if (m_cnt == AT - 1) begin m_state = 1; m_y = GY; end
          m_cnt++;
        end
      end
      default: if (edge_ev == 1) begin m_state = 0; m_y = GY; end
    endcase
    m_jq = j;
    if (j == 0) m_armed = 1;
  endtask

  // one clock: drive, predict, then compare just after the edge
  task automatic step(input string tag, input logic j, input logic t, input logic h);
    jump = j; tick = t; hit = h;
    model_step(int'(j), int'(t), int'(h));
    push_model();
    @(posedge clk3);
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset(input logic j);
    jump = j; tick = 1'b0; hit = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    push_model();
    compare_out("reset");
    @(posedge clk3);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; jump = 1'b0; tick = 1'b0; hit = 1'b0;
    model_reset();
    #2;
    do_reset(1'b0);

    // idle ignores tick/hit, then start
    step("idle", 0, 1, 1);
    step("idle", 0, 0, 0);
    step("start", 1, 0, 0);
    step("run", 0, 0, 0);

    // one jump lasts exactly AT ticks
    step("launch", 1, 0, 0);
    for (int i = 0; i < AT; i++) begin
      step("air_tick", 0, 1, 0);
      step("air_gap", 0, 0, 0);
    end

    // tick on the launch cycle is not air time
    step("launch_tick", 1, 1, 0);
    for (int i = 0; i < AT; i++) step("air_tick2", 0, 1, 0);
    step("run2", 0, 0, 0);

    // held button gives one launch; re-press in air ignored
    for (int i = 0; i < 20; i++) step("held", 1, (i % 5 == 4) ? 1'b1 : 1'b0, 0);
    step("release", 0, 0, 0);
    step("launch3", 1, 0, 0);
    step("air_rel", 0, 0, 0);
    step("double", 1, 0, 0);
    step("air_rel2", 0, 0, 0);

    // hit beats expiry on the last tick
    for (int i = 0; i < AT - 1; i++) step("air_tick3", 0, 1, 0);
    step("hit_expiry", 0, 1, 1);
    step("over_hold", 0, 1, 0);
    step("to_idle", 1, 0, 0);
    step("idle2", 0, 0, 0);
    step("start2", 1, 0, 0);
    step("run3", 0, 0, 0);

    // hit beats a jump press in RUN
    step("hit_jump", 1, 1, 1);
    step("over", 0, 0, 0);
    step("to_idle2", 1, 0, 0);

    // score saturation
    step("idle3", 0, 0, 0);
    step("start3", 1, 0, 0);
    for (int i = 0; i < 10000; i++) step("sat", 0, 1, 0);
    for (int i = 0; i < 5; i++) step("sat_hold", 0, 1, 0);

    // asynchronous reset mid-air
    step("launch4", 1, 0, 0);
    step("air4", 0, 1, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    push_model();
    compare_out("async_rst");
    @(posedge clk3);
    #1;
    rst = 1'b0;
    step("post_rst", 0, 1, 0);

    // button held through reset is not a press
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step("held_rst", 1, 0, 0);
    step("arm", 0, 0, 0);
    step("start4", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
